// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the UART transmit controller.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic IDLE_BIT  = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

endpackage

// File: rtl/uart_tx_fsm_if.sv
// Word request, serializer handshake and serial line of the UART transmitter.
interface uart_tx_fsm_if #(parameter int WIDTH = 8);

    logic [WIDTH-1:0] P_DATA;
    logic             DATA_VALID;
    logic             PAR_EN;
    logic             PAR_TYP;
    logic             ser_data;
    logic             ser_done;
    logic             ser_en;
    logic             Busy;
    logic             TX_OUT;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, ser_data, ser_done,
        input  ser_en, Busy, TX_OUT
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, ser_data, ser_done,
        output ser_en, Busy, TX_OUT
    );

endinterface

// File: rtl/uart_tx_fsm_parity_calc.sv
// Combinational parity of a parallel word; the FSM latches the result on acceptance.
module parity_calc
    import uart_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             par_typ,
    output logic             par_bit
);

    // even parity makes the total count of ones even; odd parity inverts it
    always_comb begin
        par_bit = 1'b0;
        case (par_typ)
            PAR_EVEN: par_bit = ^data;
            PAR_ODD:  par_bit = ~^data;
            default:  par_bit = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit frame sequencer: start bit, serializer data bits, optional parity, stop bit.
module uart_tx_fsm
    import uart_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_fsm_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    tx_state_e        state_q, state_d;
    logic             par_en_q, par_en_d;
    logic             par_bit_q, par_bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept_s;
    logic             par_calc_s;
    logic [CNT_W-1:0] data_cycles_s;
    logic             data_exit_s;

    parity_calc #(.WIDTH(WIDTH)) u_parity_calc (
        .data    (bus.P_DATA),
        .par_typ (bus.PAR_TYP),
        .par_bit (par_calc_s)
    );

    assign accept_s      = (state_q == ST_IDLE) && bus.DATA_VALID;
    // cnt_q never exceeds WIDTH-1 inside DATA, so the +1 cannot overflow
    assign data_cycles_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    // the cycle count only guards against a serializer that never signals done
    assign data_exit_s   = bus.ser_done || (data_cycles_s == CNT_W'(WIDTH));

    // state and frame context registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            cnt_q     <= cnt_d;
        end
    end

    // next state, parity capture and data-cycle count
    always_comb begin
        state_d   = state_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d   = ST_START;
                    par_en_d  = bus.PAR_EN;
                    par_bit_d = par_calc_s;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = ST_DATA;
                cnt_d   = {CNT_W{1'b0}};
            end
            ST_DATA: begin
                cnt_d = data_cycles_s;
                if (data_exit_s) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: state_d = ST_STOP;
            ST_STOP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // line, busy and serializer enable decoded from the registered state
    always_comb begin
        bus.TX_OUT = IDLE_BIT;
        bus.ser_en = 1'b0;
        bus.Busy   = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE:   bus.TX_OUT = IDLE_BIT;
            ST_START: begin
                bus.TX_OUT = START_BIT;
                bus.ser_en = 1'b1;
            end
            ST_DATA: begin
                bus.TX_OUT = bus.ser_data;
                bus.ser_en = ~bus.ser_done;
            end
            ST_PARITY: bus.TX_OUT = par_bit_q;
            ST_STOP:   bus.TX_OUT = STOP_BIT;
            default:   bus.TX_OUT = IDLE_BIT;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed and randomized frames checked against a per-frame expected bit list.
module tb_uart_tx_fsm;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_fsm_if #(.WIDTH(WIDTH)) bus ();

    uart_tx_fsm #(.WIDTH(WIDTH)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    logic [WIDTH-1:0] p_data     = '0;
    logic             data_valid = 1'b0;
    logic             par_en     = 1'b0;
    logic             par_typ    = 1'b0;
    logic             force_done = 1'b0;
    logic             tie_zero   = 1'b0;

    assign bus.P_DATA     = p_data;
    assign bus.DATA_VALID = data_valid;
    assign bus.PAR_EN     = par_en;
    assign bus.PAR_TYP    = par_typ;

    // serializer model: loads while idle, presents bit n-1 after n shifts
    logic [WIDTH-1:0] sh   = '0;
    logic             sd_q = 1'b0;
    int               scnt = 0;
    always @(posedge clk) begin
        if (bus.Busy === 1'b0) begin
            sh   <= bus.P_DATA;
            scnt <= 0;
        end else if (bus.ser_en === 1'b1) begin
            sd_q <= sh[0];
            sh   <= sh >> 1;
            scnt <= scnt + 1;
        end
    end
    assign bus.ser_data = sd_q;
    assign bus.ser_done = force_done | (~tie_zero & (scnt == WIDTH));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " tx"},   bus.TX_OUT, 1'b1);
        check({tag, " busy"}, bus.Busy,   1'b0);
        check({tag, " sen"},  bus.ser_en, 1'b0);
    endtask

    // one frame: idle cycle with request, then every frame cycle compared
    task automatic run_frame(input logic [WIDTH-1:0] d, input logic pen, input logic ptyp,
                             input bit hold, input bit keep, input int done_at,
                             input bit tie0, input int rst_at);
        logic q[$];
        logic en_q[$];
        int   nd;
        logic par;
        nd  = (done_at > 0 && done_at < WIDTH) ? done_at : WIDTH;
        par = 1'($countones(d) % 2) ^ ptyp;
        q.push_back(1'b0);
        en_q.push_back(1'b1);
        for (int i = 0; i < nd; i++) begin
            q.push_back(d[i]);
            en_q.push_back(!((i + 1) == done_at || (!tie0 && (i + 1) == WIDTH)));
        end
        if (pen) begin
            q.push_back(par);
            en_q.push_back(1'b0);
        end
        q.push_back(1'b1);
        en_q.push_back(1'b0);

        @(negedge clk);
        p_data     = d;
        par_en     = pen;
        par_typ    = ptyp;
        data_valid = 1'b1;
        force_done = 1'b0;
        tie_zero   = tie0;
        #1 check_idle("pre");

        for (int c = 0; c < q.size(); c++) begin
            @(negedge clk);
            force_done = (done_at > 0 && c == done_at);
            p_data     = WIDTH'($urandom);
            par_en     = 1'($urandom_range(1, 0));
            par_typ    = 1'($urandom_range(1, 0));
            data_valid = hold ? 1'b1 : 1'($urandom_range(1, 0));
            if (c == q.size() - 1) data_valid = keep;
            if (rst_at > 0 && c == rst_at) begin
                data_valid = 1'b0;
                rst        = 1'b1;
            end
            #1;
            check($sformatf("tx d=%h c%0d", d, c),   bus.TX_OUT, q[c]);
            check($sformatf("busy d=%h c%0d", d, c), bus.Busy,   1'b1);
            check($sformatf("sen d=%h c%0d", d, c),  bus.ser_en, en_q[c]);
            if (rst_at > 0 && c == rst_at) begin
                @(negedge clk);
                rst = 1'b0;
                #1 check_idle("post-rst");
                force_done = 1'b0;
                return;
            end
        end
        force_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 check_idle("reset");
        @(negedge clk);
        rst = 1'b0;

        run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);

        run_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0);
        run_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0);
        run_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0);

        run_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 4);
        run_frame(8'h5B, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);

        run_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0);
        run_frame(8'hE7, 1'b1, 1'b0, 1'b0, 1'b0, 5, 1'b0, 0);
        run_frame(8'h18, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);

        for (int k = 0; k < 20; k++) begin
            logic [WIDTH-1:0] rd;
            int               rdone;
            rd    = WIDTH'($urandom);
            rdone = ($urandom_range(3, 0) == 0) ? int'($urandom_range(WIDTH - 1, 1)) : 0;
            run_frame(rd, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                      1'($urandom_range(1, 0)), 1'b0, rdone, 1'b0, 0);
        end

        @(negedge clk);
        #1 check_idle("final");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
